if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble instruction placed in IF/ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit request to hold PC and IF/ID.
REQ-006 pcsrc  input  1  redirect request from the MEM-stage branch unit.
REQ-007 pc_target  input  32  redirect address, valid when pcsrc=1.
REQ-008 ifflush  input  1  squash the IF/ID register contents.
REQ-009 imem_addr  output  32  instruction memory address, combinational copy of the PC register.
REQ-010 imem_rdata  input  32  instruction word, combinationally returned for imem_addr in the same cycle.
REQ-011 ifid_pc  output  32  PC of the instruction held in IF/ID.
REQ-012 ifid_pc4  output  32  ifid_pc + 4, mod 2^32.
REQ-013 ifid_instr  output  32  instruction held in IF/ID.
REQ-014 ifid_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-015 redirect_cnt  output  32  count of redirect cycles; present only with IF_PERF_CNT_EN.
REQ-016 stall_cnt  output  32  count of effective stall cycles; present only with IF_PERF_CNT_EN.

Function
REQ-017 PC update priority per cycle SHALL be: rst > pcsrc > stall > sequential.
REQ-018 pcsrc=1: PC SHALL load {pc_target[31:2],2'b00} at the next edge, regardless of stall.
REQ-019 pcsrc=0, stall=1: PC SHALL hold.
REQ-020 pcsrc=0, stall=0: PC SHALL load PC+4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-021 IF/ID update priority per cycle SHALL be: rst > ifflush > stall > load.
REQ-022 ifflush=1: IF/ID SHALL load ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc=0, ifid_pc4=4, regardless of stall.
REQ-023 ifflush=0, stall=1: IF/ID SHALL hold all fields.
REQ-024 ifflush=0, stall=0: IF/ID SHALL load ifid_instr=imem_rdata, ifid_pc=PC, ifid_pc4=PC+4, ifid_valid=1.
REQ-025 pcsrc and ifflush SHALL act independently; pcsrc without ifflush redirects PC and still loads IF/ID normally, ifflush without pcsrc squashes IF/ID with sequential or held PC.
REQ-026 Fetch-to-IF/ID latency SHALL be one cycle; the first target instruction SHALL appear in IF/ID two edges after the pcsrc edge.
REQ-027 ifid_pc4 SHALL be registered, not derived combinationally from ifid_pc.

Reset
REQ-028 rst=1 at an edge SHALL set PC=RESET_PC, ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc=0, ifid_pc4=4, overriding pcsrc, stall, ifflush.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard the pending state; the first fetch after deassertion SHALL use RESET_PC.
REQ-030 With IF_PERF_CNT_EN, rst SHALL clear redirect_cnt and stall_cnt to 0.

Configuration
REQ-031 Macro IF_PERF_CNT_EN defined: redirect_cnt SHALL increment each cycle with pcsrc=1; stall_cnt SHALL increment each cycle with stall=1 and pcsrc=0; both SHALL saturate at 32'hFFFF_FFFF.
REQ-032 Macro IF_PERF_CNT_EN undefined: redirect_cnt and stall_cnt ports and counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Reset, RESET_PC=0, 3 cycles free-run, imem returns addr-tagged words -> imem_addr 0,4,8,C; ifid_pc 0,4,8 with valid=1 from edge 2.
REQ-034 At PC=0x10 assert pcsrc=1, ifflush=1, pc_target=0x103 for one cycle -> next imem_addr 0x100; IF/ID holds NOP_INSTR, valid=0; next cycle ifid_pc=0x100, valid=1.
REQ-035 stall=1 for 3 cycles at PC=0x20 -> imem_addr stays 0x20, IF/ID fields unchanged; stall_cnt +3 with IF_PERF_CNT_EN.
REQ-036 stall=1, pcsrc=1, ifflush=1, pc_target=0x40 same cycle -> PC=0x40, IF/ID bubble; redirect_cnt +1, stall_cnt +0.
REQ-037 PC forced to 0xFFFF_FFFC, no stall -> next imem_addr 0x0; ifid_pc4 of that instruction = 0x0.
REQ-038 rst=1 during stall=1 with pcsrc=1 -> PC=RESET_PC, valid=0, counters 0, no redirect applied.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register with redirect/stall handling and the IF/ID pipeline register.
// Optional performance counters (redirect_cnt, stall_cnt) are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic [31:0] pc_target,
  input  logic        ifflush,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [31:0] stall_cnt
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  // Redirect targets are forced word-aligned, so the low two bits are never used.
  logic        w_unused_tgt_lsb;

  assign w_pc_plus4       = r_pc + 32'd4;
  assign w_unused_tgt_lsb = ^pc_target[1:0];

  always_comb begin
    w_pc_next = r_pc;
    if (pcsrc) begin
      w_pc_next = {pc_target[31:2], 2'b00};
    end else if (!stall) begin
      w_pc_next = w_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ifflush) begin
      r_ifid_pc    <= '0;
      r_ifid_pc4   <= 32'd4;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (!stall) begin
      r_ifid_pc    <= r_pc;
      r_ifid_pc4   <= w_pc_plus4;
      r_ifid_instr <= imem_rdata;
      r_ifid_valid <= 1'b1;
    end
  end

  assign imem_addr  = r_pc;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_instr = r_ifid_instr;
  assign ifid_valid = r_ifid_valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_redirect_cnt;
  logic [31:0] r_stall_cnt;

  // Stall cycles are counted only when not overridden by a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (pcsrc && (r_redirect_cnt != '1)) begin
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
      end
      if (stall && !pcsrc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign redirect_cnt = r_redirect_cnt;
  assign stall_cnt    = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with fixed expectations plus a
// randomized run compared every cycle against a behavioural fetch-stage model.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, pcsrc, ifflush;
  logic [31:0] pc_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ifid_pc, ifid_pc4, ifid_instr;
  logic        ifid_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] redirect_cnt, stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_rcnt, m_scnt;
  logic        m_valid;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  if_stage #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .pcsrc     (pcsrc),
    .pc_target (pc_target),
    .ifflush   (ifflush),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .ifid_pc   (ifid_pc),
    .ifid_pc4  (ifid_pc4),
    .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .redirect_cnt(redirect_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic p, input logic f,
                       input logic [31:0] t);
    rst = r; stall = s; pcsrc = p; ifflush = f; pc_target = t;
  endtask

  task automatic check_model();
    check("mdl_imem_addr", imem_addr, m_pc);
    check("mdl_ifid_pc", ifid_pc, m_ipc);
    check("mdl_ifid_pc4", ifid_pc4, m_ipc4);
    check("mdl_ifid_instr", ifid_instr, m_instr);
    check("mdl_ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
`ifdef IF_PERF_CNT_EN
    check("mdl_redirect_cnt", redirect_cnt, m_rcnt);
    check("mdl_stall_cnt", stall_cnt, m_scnt);
`endif
  endtask

  // One clock: advance the model from the inputs present at the edge, then compare.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_pc = RST_PC; m_ipc = 0; m_ipc4 = 4; m_instr = NOP; m_valid = 1'b0;
      m_rcnt = 0; m_scnt = 0;
    end else begin
      if (ifflush) begin
        m_ipc = 0; m_ipc4 = 4; m_instr = NOP; m_valid = 1'b0;
      end else if (!stall) begin
        m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = imem_word(m_pc); m_valid = 1'b1;
      end
      if (pcsrc) m_pc = pc_target & 32'hFFFF_FFFC;
      else if (!stall) m_pc = m_pc + 4;
      if (pcsrc && m_rcnt != 32'hFFFF_FFFF) m_rcnt = m_rcnt + 1;
      if (stall && !pcsrc && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
    end
    #1;
    check_model();
  endtask

  initial begin
    m_pc = 'x; m_ipc = 'x; m_ipc4 = 'x; m_instr = 'x; m_valid = 1'bx; m_rcnt = 'x; m_scnt = 'x;
    drive(1, 0, 0, 0, 32'h0);
    step();
    step();
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_ifid_instr", ifid_instr, NOP);
    check("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_ifid_pc", ifid_pc, 32'd0);
    check("rst_ifid_pc4", ifid_pc4, 32'd4);

    // Free-run from reset
    drive(0, 0, 0, 0, 32'h0);
    for (int unsigned k = 1; k <= 3; k++) begin
      step();
      check("run_imem_addr", imem_addr, 32'(4 * k));
      check("run_ifid_pc", ifid_pc, 32'(4 * (k - 1)));
      check("run_ifid_valid", {31'd0, ifid_valid}, 32'd1);
    end
    step();
    check("run_pc10", imem_addr, 32'h10);

    // Redirect with flush, misaligned target
    drive(0, 0, 1, 1, 32'h103);
    step();
    check("redir_imem_addr", imem_addr, 32'h100);
    check("redir_bubble_instr", ifid_instr, NOP);
    check("redir_bubble_valid", {31'd0, ifid_valid}, 32'd0);
    drive(0, 0, 0, 0, 32'h0);
    step();
    check("redir_tgt_pc", ifid_pc, 32'h100);
    check("redir_tgt_valid", {31'd0, ifid_valid}, 32'd1);
    check("redir_tgt_instr", ifid_instr, imem_word(32'h100));

    // Redirect without flush loads IF/ID normally, then stall 3 cycles at 0x20
    drive(0, 0, 1, 0, 32'h20);
    step();
    check("nf_redir_ifid_pc", ifid_pc, 32'h104);
    check("nf_redir_valid", {31'd0, ifid_valid}, 32'd1);
    drive(0, 1, 0, 0, 32'h0);
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      check("stall_imem_addr", imem_addr, 32'h20);
      check("stall_ifid_pc", ifid_pc, 32'h104);
      check("stall_ifid_pc4", ifid_pc4, 32'h108);
      check("stall_ifid_instr", ifid_instr, imem_word(32'h104));
    end
`ifdef IF_PERF_CNT_EN
    check("stall_cnt_3", stall_cnt, 32'd3);
    check("redirect_cnt_2", redirect_cnt, 32'd2);
`endif

    // Stall, redirect and flush in the same cycle
    drive(0, 1, 1, 1, 32'h40);
    step();
    check("combo_imem_addr", imem_addr, 32'h40);
    check("combo_valid", {31'd0, ifid_valid}, 32'd0);
    check("combo_instr", ifid_instr, NOP);
    check("combo_pc4", ifid_pc4, 32'd4);
`ifdef IF_PERF_CNT_EN
    check("combo_redirect_cnt", redirect_cnt, 32'd3);
    check("combo_stall_cnt", stall_cnt, 32'd3);
`endif

    // PC wrap at the top of the address space
    drive(0, 0, 1, 0, 32'hFFFF_FFFF);
    step();
    check("wrap_pc_top", imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 32'h0);
    step();
    check("wrap_imem_addr", imem_addr, 32'h0);
    check("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    check("wrap_ifid_pc4", ifid_pc4, 32'h0);

    // Reset during stall + redirect
    drive(0, 1, 1, 0, 32'h80);
    step();
    drive(1, 1, 1, 1, 32'h200);
    step();
    check("rstmid_imem_addr", imem_addr, RST_PC);
    check("rstmid_valid", {31'd0, ifid_valid}, 32'd0);
`ifdef IF_PERF_CNT_EN
    check("rstmid_redirect_cnt", redirect_cnt, 32'd0);
    check("rstmid_stall_cnt", stall_cnt, 32'd0);
`endif
    drive(0, 0, 0, 0, 32'h0);
    step();
    check("rstmid_first_fetch", ifid_pc, RST_PC);
    check("rstmid_next_addr", imem_addr, RST_PC + 32'd4);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 12),
            $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
